serial_word_rx: RTL and testbench

- Receiver end of the 20-bit word link. It deserializes an asynchronous, start/stop-framed serial stream on SDI back into a 20-bit parallel word Y.
- It is the counterpart of the word transmitter that drives the board's serial pin.
- Y is held stable between frames so it can drive the output pads directly. The same pads are used by the parallel pass-through test designs.
- Each completed frame raises a one-cycle valid strobe; a malformed frame raises a one-cycle error strobe.

---
 rtl/serial_word_rx.sv | 166 ++++++++++++++++
 tb/tb_serial_word_rx.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_rx.sv
// serial_word_rx: receive end of the 20-bit word link.
// Deserializes a start/stop framed asynchronous stream on SDI (LSB first)
// into a parallel word Y that is held stable between frames.
//
// Ports:
//   CLK     - system clock, rising edge
//   RST     - synchronous, active-high reset
//   SDI     - serial data in, asynchronous to CLK, idles high
//   Y       - last correctly received word
//   Y_VALID - one-cycle pulse when Y is updated
//   FERR    - one-cycle pulse when the stop bit is sampled low
//   BUSY    - high while a frame is in progress
module serial_word_rx #(
  parameter int WIDTH        = 20,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SDI,
  output logic [WIDTH-1:0] Y,
  output logic             Y_VALID,
  output logic             FERR,
  output logic             BUSY
);

  localparam int CYC_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = $clog2(WIDTH + 1);

  localparam logic [CYC_W-1:0] CYC_ONE   = CYC_W'(1);
  localparam logic [CYC_W-1:0] HALF_LAST = CYC_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CYC_W-1:0] FULL_LAST = CYC_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               sync1_q, sync1_d;
  logic               sync2_q, sync2_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic [BIT_W-1:0]   bitn_q, bitn_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic               y_valid_q, y_valid_d;
  logic               ferr_q, ferr_d;
  logic               busy_q, busy_d;
  logic               s_sdi;

  assign s_sdi   = sync2_q;
  assign Y       = y_q;
  assign Y_VALID = y_valid_q;
  assign FERR    = ferr_q;
  assign BUSY    = busy_q;

  // Next-state and output logic for the synchronizer and the frame FSM.
  always_comb begin
    sync1_d   = SDI;
    sync2_d   = sync1_q;
    state_d   = state_q;
    cyc_d     = cyc_q;
    bitn_d    = bitn_q;
    shift_d   = shift_q;
    y_d       = y_q;
    y_valid_d = 1'b0;
    ferr_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!s_sdi) begin
          cyc_d   = '0;
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end

      // Half a bit period lands the sample in the middle of the start bit;
      // every later sample is a whole bit period on, so also mid-bit.
      ST_START: begin
        if (cyc_q == HALF_LAST) begin
          cyc_d = '0;
          if (!s_sdi) begin
            bitn_d  = '0;
            state_d = ST_DATA;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cyc_d = cyc_q + CYC_ONE;
        end
      end

      ST_DATA: begin
        if (cyc_q == FULL_LAST) begin
          cyc_d   = '0;
          shift_d = {s_sdi, shift_q[WIDTH-1:1]};
          if (bitn_q == LAST_BIT) begin
            bitn_d  = '0;
            state_d = ST_STOP;
          end else begin
            bitn_d = bitn_q + BIT_ONE;
          end
        end else begin
          cyc_d = cyc_q + CYC_ONE;
        end
      end

      // Leaving mid stop bit lets IDLE catch a start edge that follows
      // the stop bit with no gap.
      ST_STOP: begin
        if (cyc_q == FULL_LAST) begin
          cyc_d   = '0;
          state_d = ST_IDLE;
          if (s_sdi) begin
            y_d       = shift_q;
            y_valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cyc_d = cyc_q + CYC_ONE;
        end
      end

      default: begin
        cyc_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, counter, data and strobe registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= ST_IDLE;
      cyc_q     <= '0;
      bitn_q    <= '0;
      shift_q   <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      bitn_q    <= bitn_d;
      shift_q   <= shift_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
    end
  end

endmodule

// File: tb/tb_serial_word_rx.sv
// tb_serial_word_rx: self-checking bench for serial_word_rx.
// Frames are built bit by bit from their definition (start, LSB-first data,
// stop); the expected Y is simply the last word sent with a good stop bit.
module tb_serial_word_rx;

  localparam int W   = 20;
  localparam int CPB = 16;
  localparam int LAT = 2 + CPB / 2 + (W + 1) * CPB + 1;
  localparam int FRAME = (W + 2) * CPB;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sdi = 1'b1;
  logic [W-1:0] y;
  logic         y_valid;
  logic         ferr;
  logic         busy;

  int errors = 0;
  int checks = 0;

  int cyc_cnt = 0;
  int vld_cnt = 0;
  int ferr_cnt = 0;
  int both_cnt = 0;
  int long_cnt = 0;
  int last_vld_cyc = 0;
  logic prev_vld = 1'b0;
  logic prev_ferr = 1'b0;

  logic [W-1:0] exp_y = '0;

  serial_word_rx #(.WIDTH(W), .CLKS_PER_BIT(CPB)) dut (
    .CLK     (clk),
    .RST     (rst),
    .SDI     (sdi),
    .Y       (y),
    .Y_VALID (y_valid),
    .FERR    (ferr),
    .BUSY    (busy)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle stamp used for latency measurements.
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Strobe monitor: counts pulses and records when Y_VALID fired.
  always @(negedge clk) begin
    if (y_valid) begin
      vld_cnt      <= vld_cnt + 1;
      last_vld_cyc <= cyc_cnt;
    end
    if (ferr) ferr_cnt <= ferr_cnt + 1;
    if (y_valid && ferr) both_cnt <= both_cnt + 1;
    if ((y_valid && prev_vld) || (ferr && prev_ferr)) long_cnt <= long_cnt + 1;
    prev_vld  <= y_valid;
    prev_ferr <= ferr;
  end

  // Global time limit so the run can never hang.
  initial begin
    #(10 * 200000);
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one complete frame starting at a negedge; st is the cycle stamp
  // at which the start bit was driven.
  task automatic send_frame(input logic [W-1:0] word, input logic stop, output int st);
    sdi = 1'b0;
    st  = cyc_cnt;
    tick(CPB);
    for (int i = 0; i < W; i++) begin
      sdi = word[i];
      tick(CPB);
    end
    sdi = stop;
    tick(CPB);
    sdi = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    sdi = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
    checks++; if (y !== 20'h00000) begin errors++; $display("FAIL reset_y: got %h expected %h", y, 20'h00000); end
    checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL reset_y_valid: got %b expected 0", y_valid); end
    checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", ferr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    exp_y = '0;
    tick(5);
  endtask

  task automatic test_good_frame;
    int st, v0, f0;
    v0 = vld_cnt; f0 = ferr_cnt;
    send_frame(20'hABCDE, 1'b1, st);
    exp_y = 20'hABCDE;
    tick(2);
    checks++; if (y !== exp_y) begin errors++; $display("FAIL good_y: got %h expected %h", y, exp_y); end
    checks++; if (vld_cnt - v0 !== 1) begin errors++; $display("FAIL good_vld_count: got %0d expected 1", vld_cnt - v0); end
    checks++; if (last_vld_cyc - st !== LAT) begin errors++; $display("FAIL good_latency: got %0d expected %0d", last_vld_cyc - st, LAT); end
    checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL good_ferr: got %0d expected 0", ferr_cnt - f0); end
    tick(20);
  endtask

  task automatic test_framing_error;
    int st, v0, f0;
    v0 = vld_cnt; f0 = ferr_cnt;
    send_frame(20'h12345, 1'b0, st);
    tick(40);
    checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_count: got %0d expected 1", ferr_cnt - f0); end
    checks++; if (y !== exp_y) begin errors++; $display("FAIL ferr_y_held: got %h expected %h", y, exp_y); end
    checks++; if (vld_cnt - v0 !== 0) begin errors++; $display("FAIL ferr_no_valid: got %0d expected 0", vld_cnt - v0); end
  endtask

  task automatic test_glitch;
    int v0, f0;
    logic busy_seen;
    v0 = vld_cnt; f0 = ferr_cnt; busy_seen = 1'b0;
    sdi = 1'b0;
    tick(3);
    sdi = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (busy) busy_seen = 1'b1;
      tick(1);
    end
    tick(10);
    checks++; if (busy_seen !== 1'b1) begin errors++; $display("FAIL glitch_busy_pulse: got %b expected 1", busy_seen); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end: got %b expected 0", busy); end
    checks++; if (vld_cnt - v0 !== 0) begin errors++; $display("FAIL glitch_valid: got %0d expected 0", vld_cnt - v0); end
    checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL glitch_ferr: got %0d expected 0", ferr_cnt - f0); end
    checks++; if (y !== exp_y) begin errors++; $display("FAIL glitch_y: got %h expected %h", y, exp_y); end
  endtask

  task automatic test_back_to_back;
    int st, v0, c1;
    v0 = vld_cnt;
    send_frame(20'h00001, 1'b1, st);
    c1 = last_vld_cyc;
    checks++; if (y !== 20'h00001) begin errors++; $display("FAIL b2b_y1: got %h expected %h", y, 20'h00001); end
    send_frame(20'hFFFFF, 1'b1, st);
    exp_y = 20'hFFFFF;
    tick(2);
    checks++; if (y !== exp_y) begin errors++; $display("FAIL b2b_y2: got %h expected %h", y, exp_y); end
    checks++; if (vld_cnt - v0 !== 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", vld_cnt - v0); end
    checks++; if (last_vld_cyc - c1 !== FRAME) begin errors++; $display("FAIL b2b_spacing: got %0d expected %0d", last_vld_cyc - c1, FRAME); end
    tick(20);
  endtask

  task automatic test_break;
    int v0, f0, n;
    v0 = vld_cnt; f0 = ferr_cnt; n = 0;
    sdi = 1'b0;
    while ((ferr_cnt - f0 < 3) && (n < 2000)) begin
      tick(1);
      n++;
    end
    sdi = 1'b1;
    tick(400);
    checks++; if (ferr_cnt - f0 !== 3) begin errors++; $display("FAIL break_ferr_count: got %0d expected 3", ferr_cnt - f0); end
    checks++; if (vld_cnt - v0 !== 0) begin errors++; $display("FAIL break_no_valid: got %0d expected 0", vld_cnt - v0); end
    checks++; if (y !== exp_y) begin errors++; $display("FAIL break_y: got %h expected %h", y, exp_y); end
  endtask

  task automatic test_reset_mid_frame;
    int st, v0, f0;
    logic [W-1:0] w;
    w = 20'h3C3C3;
    v0 = vld_cnt; f0 = ferr_cnt;
    sdi = 1'b0;
    tick(CPB);
    for (int i = 0; i < 10; i++) begin
      sdi = w[i];
      tick(CPB);
    end
    sdi = w[10];
    tick(8);
    rst = 1'b1;
    sdi = 1'b1;
    tick(1);
    rst = 1'b0;
    exp_y = '0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (y !== exp_y) begin errors++; $display("FAIL midrst_y: got %h expected %h", y, exp_y); end
    tick(40);
    checks++; if ((vld_cnt - v0) + (ferr_cnt - f0) !== 0) begin errors++; $display("FAIL midrst_strobes: got %0d expected 0", (vld_cnt - v0) + (ferr_cnt - f0)); end
    v0 = vld_cnt;
    send_frame(20'h5A5A5, 1'b1, st);
    exp_y = 20'h5A5A5;
    tick(2);
    checks++; if (y !== exp_y) begin errors++; $display("FAIL midrst_next_y: got %h expected %h", y, exp_y); end
    checks++; if (vld_cnt - v0 !== 1) begin errors++; $display("FAIL midrst_next_valid: got %0d expected 1", vld_cnt - v0); end
    tick(20);
  endtask

  task automatic test_random_frames;
    int st, v0, f0, gap;
    logic [W-1:0] w;
    logic stop;
    for (int k = 0; k < 8; k++) begin
      w    = W'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      v0 = vld_cnt; f0 = ferr_cnt;
      send_frame(w, stop, st);
      if (stop) exp_y = w;
      checks++; if (y !== exp_y) begin errors++; $display("FAIL rand_y[%0d]: got %h expected %h", k, y, exp_y); end
      checks++; if (vld_cnt - v0 !== (stop ? 1 : 0)) begin errors++; $display("FAIL rand_valid[%0d]: got %0d expected %0d", k, vld_cnt - v0, stop ? 1 : 0); end
      checks++; if (ferr_cnt - f0 !== (stop ? 0 : 1)) begin errors++; $display("FAIL rand_ferr[%0d]: got %0d expected %0d", k, ferr_cnt - f0, stop ? 0 : 1); end
      if (stop) begin
        checks++; if (last_vld_cyc - st !== LAT) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", k, last_vld_cyc - st, LAT); end
      end
      gap = stop ? $urandom_range(0, 30) : $urandom_range(4, 30);
      tick(gap);
    end
    tick(20);
  endtask

  task automatic test_strobe_rules;
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL strobe_overlap: got %0d expected 0", both_cnt); end
    checks++; if (long_cnt !== 0) begin errors++; $display("FAIL strobe_width: got %0d expected 0", long_cnt); end
  endtask

  initial begin
    tick(1);
    test_reset();
    test_good_frame();
    test_framing_error();
    test_glitch();
    test_back_to_back();
    test_break();
    test_reset_mid_frame();
    test_random_frames();
    test_strobe_rules();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
